// File: rtl/pcie_rx_tag_arb.sv
// Round-robin read-request scheduler and per-channel tag allocator for the cpld0/1/2 completion channels.
// Optional per-channel outstanding-tag watchdog is built when PCIE_TAG_TIMEOUT_EN is defined.
module pcie_rx_tag_arb #(
    parameter int C_TAGS_PER_CH = 8,
    parameter int C_ADDR_WIDTH  = 64,
    parameter int C_LEN_WIDTH   = 10,
    parameter int C_TIMEOUT_CYC = 65535
) (
    input  logic                    pcie_user_clk,
    input  logic                    pcie_user_rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [C_ADDR_WIDTH-1:0] req0_addr,
    input  logic [C_LEN_WIDTH-1:0]  req0_len,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [C_ADDR_WIDTH-1:0] req1_addr,
    input  logic [C_LEN_WIDTH-1:0]  req1_len,
    input  logic                    req2_valid,
    output logic                    req2_ready,
    input  logic [C_ADDR_WIDTH-1:0] req2_addr,
    input  logic [C_LEN_WIDTH-1:0]  req2_len,
    output logic                    tx_rd_valid,
    input  logic                    tx_rd_ready,
    output logic [C_ADDR_WIDTH-1:0] tx_rd_addr,
    output logic [C_LEN_WIDTH-1:0]  tx_rd_len,
    output logic [7:0]              tx_rd_tag,
    input  logic                    cpld_fifo_wr_en,
    input  logic [7:0]              cpld_fifo_tag,
    input  logic                    cpld_fifo_tag_last,
    output logic [4:0]              ch0_outstanding,
    output logic [4:0]              ch1_outstanding,
    output logic [4:0]              ch2_outstanding,
    output logic                    all_idle,
    output logic                    tag_err,
    output logic                    tag_timeout_err
);

    localparam logic [15:0] SLOT_MASK = 16'((32'd1 << C_TAGS_PER_CH) - 32'd1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
        return n;
    endfunction

    function automatic logic [3:0] lowest_free(input logic [15:0] used);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 15; i >= 0; i--) s = (!used[i] && SLOT_MASK[i]) ? 4'(i) : s;
        return s;
    endfunction

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
        logic [2:0] s;
        s = {1'b0, p} + 3'(k);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    state_e                          state_r, state_nxt_s;
    logic [2:0][15:0]                bitmap_r, bitmap_nxt_s, alloc_mask_s, free_mask_s;
    logic [2:0]                      req_valid_s, elig_s, ready_s, free_ok_s;
    logic [2:0][C_ADDR_WIDTH-1:0]    req_addr_s;
    logic [2:0][C_LEN_WIDTH-1:0]     req_len_s;
    logic [1:0]                      ptr_r, win_s, gnt_ch_r;
    logic                            win_any_s, hs_s, free_legal_s, free_err_s;
    logic [C_ADDR_WIDTH-1:0]         addr_r;
    logic [C_LEN_WIDTH-1:0]          len_r;
    logic [7:0]                      tag_r;
    logic [2:0][4:0]                 cnt_r;
    logic                            all_idle_r, tag_err_r;

    assign req_valid_s = {req2_valid, req1_valid, req0_valid};
    assign req_addr_s  = {req2_addr, req1_addr, req0_addr};
    assign req_len_s   = {req2_len, req1_len, req0_len};
    assign hs_s        = (state_r == ST_ISSUE) && tx_rd_ready;
    assign free_err_s  = cpld_fifo_wr_en && cpld_fifo_tag_last && !free_legal_s;

    // Eligibility per channel and round-robin winner starting at the pointer
    always_comb begin
        elig_s    = 3'd0;
        win_s     = ptr_r;
        win_any_s = 1'b0;
        for (int n = 0; n < 3; n++) elig_s[n] = req_valid_s[n] && ((bitmap_r[n] | ~SLOT_MASK) != 16'hFFFF);
        // Walk from farthest to nearest so the channel at the pointer wins last-write
        for (int k = 2; k >= 0; k--) begin
            win_s     = elig_s[rr_idx(ptr_r, k)] ? rr_idx(ptr_r, k) : win_s;
            win_any_s = win_any_s | elig_s[rr_idx(ptr_r, k)];
        end
    end

    // Legality of a last-beat completion against the current bitmaps
    always_comb begin
        free_legal_s = 1'b0;
        if (cpld_fifo_wr_en && cpld_fifo_tag_last && (cpld_fifo_tag[7:4] <= 4'd2)) begin
            free_legal_s = SLOT_MASK[cpld_fifo_tag[3:0]] && bitmap_r[cpld_fifo_tag[5:4]][cpld_fifo_tag[3:0]];
        end else begin
            free_legal_s = 1'b0;
        end
    end

    // Next bitmaps: allocation on handshake and legal free may land in the same cycle
    always_comb begin
        alloc_mask_s = '0;
        free_mask_s  = '0;
        free_ok_s    = 3'd0;
        bitmap_nxt_s = bitmap_r;
        for (int n = 0; n < 3; n++) begin
            alloc_mask_s[n] = (hs_s && (gnt_ch_r == 2'(n))) ? (16'd1 << tag_r[3:0]) : 16'd0;
            free_ok_s[n]    = free_legal_s && (cpld_fifo_tag[5:4] == 2'(n));
            free_mask_s[n]  = free_ok_s[n] ? (16'd1 << cpld_fifo_tag[3:0]) : 16'd0;
            bitmap_nxt_s[n] = (bitmap_r[n] & ~free_mask_s[n]) | alloc_mask_s[n];
        end
    end

    // FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = win_any_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt_s = hs_s ? ST_IDLE : ST_ISSUE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs; a handshake coinciding with reset is not acknowledged
    always_comb begin
        tx_rd_valid = 1'b0;
        ready_s     = 3'd0;
        case (state_r)
            ST_ISSUE: begin
                tx_rd_valid = 1'b1;
                ready_s     = (tx_rd_ready && !pcie_user_rst) ? (3'd1 << gnt_ch_r) : 3'd0;
            end
            ST_IDLE: begin
                tx_rd_valid = 1'b0;
                ready_s     = 3'd0;
            end
            default: begin
                tx_rd_valid = 1'b0;
                ready_s     = 3'd0;
            end
        endcase
    end

    // State register, grant capture, bitmaps, pointer and status registers
    always_ff @(posedge pcie_user_clk) begin
        if (pcie_user_rst) begin
            state_r    <= ST_IDLE;
            bitmap_r   <= '0;
            ptr_r      <= 2'd0;
            gnt_ch_r   <= 2'd0;
            addr_r     <= '0;
            len_r      <= '0;
            tag_r      <= 8'd0;
            cnt_r      <= '0;
            all_idle_r <= 1'b1;
            tag_err_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            bitmap_r <= bitmap_nxt_s;
            if ((state_r == ST_IDLE) && win_any_s) begin
                gnt_ch_r <= win_s;
                addr_r   <= req_addr_s[win_s];
                len_r    <= req_len_s[win_s];
                tag_r    <= {2'b00, win_s, lowest_free(bitmap_r[win_s])};
            end
            if (hs_s) begin
                ptr_r <= (gnt_ch_r == 2'd2) ? 2'd0 : gnt_ch_r + 2'd1;
            end
            for (int n = 0; n < 3; n++) cnt_r[n] <= popcount16(bitmap_r[n]);
            all_idle_r <= (bitmap_nxt_s == '0) && (state_nxt_s == ST_IDLE);
            tag_err_r  <= tag_err_r | free_err_s;
        end
    end

    assign req0_ready      = ready_s[0];
    assign req1_ready      = ready_s[1];
    assign req2_ready      = ready_s[2];
    assign tx_rd_addr      = addr_r;
    assign tx_rd_len       = len_r;
    assign tx_rd_tag       = tag_r;
    assign ch0_outstanding = cnt_r[0];
    assign ch1_outstanding = cnt_r[1];
    assign ch2_outstanding = cnt_r[2];
    assign all_idle        = all_idle_r;
    assign tag_err         = tag_err_r;

`ifdef PCIE_TAG_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(C_TIMEOUT_CYC);

    logic [2:0][15:0] wd_cnt_r;
    logic             wd_err_r;

    // Per-channel watchdog: runs while tags are outstanding, restarts on any legal free
    always_ff @(posedge pcie_user_clk) begin
        if (pcie_user_rst) begin
            wd_cnt_r <= '0;
            wd_err_r <= 1'b0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if ((bitmap_r[n] == 16'd0) || free_ok_s[n]) begin
                    wd_cnt_r[n] <= 16'd0;
                end else if (wd_cnt_r[n] != TO_LIMIT) begin
                    wd_cnt_r[n] <= wd_cnt_r[n] + 16'd1;
                end
                if (wd_cnt_r[n] == TO_LIMIT) wd_err_r <= 1'b1;
            end
        end
    end

    assign tag_timeout_err = wd_err_r;
`else
    assign tag_timeout_err = 1'b0;
`endif

endmodule
